rv32m_div_ctrl: RTL and testbench
=================================

Name: rv32m_div_ctrl

Overview:
- Front-end/back-end control for the RV32M divide path: accepts DIV/DIVU/REM/REMU ops from the EX stage and handles the special cases itself.
- Converts signed operands to unsigned magnitudes and issues them to the iterative unsigned divider core (non-restoring or SRT-4) through a start/done handshake.
- Sign-corrects the core's quotient/remainder and returns one 32-bit result to writeback with valid/ready backpressure.

Parameters:
- DW, 32, datapath width.
- TAG_W, 5, width of destination-register tag carried with each op.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  op offered by EX.
- in_ready  output  1  ctrl can accept op.
- in_funct3  input  3  100=DIV, 101=DIVU, 110=REM, 111=REMU; other codes treated as DIVU.
- in_rs1  input  DW  dividend.
- in_rs2  input  DW  divisor.
- in_tag  input  TAG_W  rd tag.
- flush  input  1  kill in-flight op (branch mispredict/trap).
- core_start  output  1  one-cycle start pulse to divider core.
- core_dividend  output  DW  unsigned magnitude, held stable from start until done.
- core_divisor  output  DW  unsigned magnitude, held stable from start until done.
- core_done  input  1  one-cycle completion pulse from core.
- core_quotient  input  DW  unsigned quotient, valid with core_done.
- core_remainder  input  DW  unsigned remainder, valid with core_done.
- out_valid  output  1  result available.
- out_ready  input  1  writeback accepts result.
- out_result  output  DW  final rd value.
- out_tag  output  TAG_W  tag of result.
- busy  output  1  state != IDLE (pipeline stall hint).

Behaviour:
- Reset (async, rst_n=0): state=IDLE; core_start, out_valid, out_result, out_tag, core_dividend, core_divisor = 0; in_ready=1 after release. Reset mid-operation abandons the op; no output is produced.
- in_ready = (state==IDLE), combinational. Accept when in_valid & in_ready at a posedge; latch funct3, operands, tag.
- States: IDLE, LAUNCH, WAIT, RESP, DRAIN.
- IDLE -> accept:
  - Divisor==0: result = all-ones for DIV/DIVU, rs1 for REM/REMU; go RESP directly; no core_start.
  - Signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF): DIV gives 0x80000000, REM gives 0; go RESP; no core_start.
  - Otherwise: register magnitudes (|x| for signed ops, two's complement of INT_MIN = 0x80000000 unsigned), neg_q = sign(rs1)^sign(rs2), neg_r = sign(rs1) (signed ops only); go LAUNCH.
- LAUNCH: core_start=1 for exactly this cycle; -> WAIT.
- WAIT: on core_done, select quotient (DIV*) or remainder (REM*), negate if the matching neg flag is set, register into out_result; -> RESP.
- RESP: out_valid=1; out_result/out_tag held stable while out_ready=0; on out_ready -> IDLE (out_valid low next cycle).
- Latency:
  - Special cases: out_valid asserted the cycle after accept.
  - Normal ops: accept at edge N, core_start high cycle N+1, out_valid asserted the cycle after core_done is sampled.
- flush:
  - In LAUNCH or WAIT -> DRAIN (core still running). DRAIN waits for core_done, discards it, -> IDLE.
  - flush in RESP drops out_valid next cycle -> IDLE.
  - flush in IDLE: no effect, and any simultaneous in_valid is not accepted.
  - flush and core_done in the same WAIT cycle: result discarded -> IDLE.
- core_start is never asserted outside LAUNCH. Core operands are unchanged in WAIT/DRAIN.

Optional Feature:
- Macro DIV_RESULT_REUSE_EN.
- When defined:
  - Store the last completed core op: raw rs1, rs2, signedness, quotient and remainder (post sign-correction), plus a valid bit.
  - A new op with identical rs1/rs2/signedness (e.g. DIV then REM of the same pair) skips the core and goes to RESP the cycle after accept.
  - Valid bit is cleared by reset and by flush during DRAIN; it is not updated by special-case ops.
- When not defined: every non-special op launches the core; no storage is inferred.

Test Plan:
- DIVU rs1=11 rs2=3 -> one core_start with 11/3; out_result=3; REMU same operands -> 2.
- DIV rs1=-7 (0xFFFFFFF9) rs2=2 -> core sees 7/2; out_result=0xFFFFFFFD; REM -> 0xFFFFFFFF.
- DIV rs1=10 rs2=0 -> no core_start, out_result=0xFFFFFFFF next cycle; REM rs1=10 rs2=0 -> 10.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0, no core_start.
- Backpressure: out_ready low 5 cycles -> out_valid/out_result/out_tag stable, in_ready=0; release -> in_ready=1 next cycle.
- flush in WAIT, core_done 10 cycles later -> no out_valid, in_ready stays 0 until that core_done, then 1. With DIV_RESULT_REUSE_EN: DIV 100/7 then REM 100/7 -> second op has no core_start and yields 2.

Source files
------------

// File: rtl/rv32m_div_ctrl.sv
// RV32M divide control: decodes DIV/DIVU/REM/REMU, resolves div-by-zero and signed overflow locally, launches unsigned core otherwise.
// Latency: special cases (and reuse hits) 1 cycle after accept; core ops = 1 launch cycle + core time + 1 register cycle.
// Backpressure: in_ready only in IDLE; result held in RESP until out_ready. Optional result reuse enabled by macro DIV_RESULT_REUSE_EN.
module rv32m_div_ctrl #(
    parameter int DW    = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_funct3,
    input  logic [DW-1:0]    in_rs1,
    input  logic [DW-1:0]    in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             core_start,
    output logic [DW-1:0]    core_dividend,
    output logic [DW-1:0]    core_divisor,
    input  logic             core_done,
    input  logic [DW-1:0]    core_quotient,
    input  logic [DW-1:0]    core_remainder,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam logic [DW-1:0] INT_MIN = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP, S_DRAIN} state_t;

    state_t             state_q;
    logic               core_start_q;
    logic [DW-1:0]      core_dividend_q;
    logic [DW-1:0]      core_divisor_q;
    logic               out_valid_q;
    logic [DW-1:0]      out_result_q;
    logic [TAG_W-1:0]   out_tag_q;
    logic               rem_q;
    logic               neg_quo_q;
    logic               neg_rem_q;

    // Front-end decode of the offered op (funct3 codes outside 100..111 behave as DIVU)
    logic               op_signed;
    logic               op_rem;
    logic               a_neg;
    logic               b_neg;
    logic [DW-1:0]      a_mag;
    logic [DW-1:0]      b_mag;
    logic               div_zero;
    logic               sgn_ovf;
    logic               special;
    logic [DW-1:0]      spec_res;
    logic               accept;
    logic               reuse_hit;
    logic [DW-1:0]      reuse_res;

    assign op_signed = in_funct3[2] & ~in_funct3[0];
    assign op_rem    = in_funct3[2] & in_funct3[1];
    assign a_neg     = op_signed & in_rs1[DW-1];
    assign b_neg     = op_signed & in_rs2[DW-1];
    // Negating INT_MIN wraps back to 0x80000000, which is the correct unsigned magnitude
    assign a_mag     = a_neg ? -in_rs1 : in_rs1;
    assign b_mag     = b_neg ? -in_rs2 : in_rs2;
    assign div_zero  = (in_rs2 == '0);
    assign sgn_ovf   = op_signed & (in_rs1 == INT_MIN) & (in_rs2 == '1);
    assign special   = div_zero | sgn_ovf;
    assign spec_res  = div_zero ? (op_rem ? in_rs1 : '1) : (op_rem ? '0 : INT_MIN);
    // A flush in IDLE blocks acceptance of a simultaneous offer
    assign accept    = in_valid & (state_q == S_IDLE) & ~flush;

    // Back-end sign correction of the core result
    logic [DW-1:0]      quo_fix;
    logic [DW-1:0]      rem_fix;
    logic [DW-1:0]      res_fix;

    assign quo_fix = neg_quo_q ? -core_quotient : core_quotient;
    assign rem_fix = neg_rem_q ? -core_remainder : core_remainder;
    assign res_fix = rem_q ? rem_fix : quo_fix;

`ifdef DIV_RESULT_REUSE_EN
    logic               rv_vld_q;
    logic               rv_sgn_q;
    logic [DW-1:0]      rv_rs1_q;
    logic [DW-1:0]      rv_rs2_q;
    logic [DW-1:0]      rv_quo_q;
    logic [DW-1:0]      rv_rem_q;
    logic               req_sgn_q;
    logic [DW-1:0]      req_rs1_q;
    logic [DW-1:0]      req_rs2_q;

    assign reuse_hit = rv_vld_q & (rv_rs1_q == in_rs1) & (rv_rs2_q == in_rs2) & (rv_sgn_q == op_signed);
    assign reuse_res = op_rem ? rv_rem_q : rv_quo_q;

    // Remember raw operands of the op in flight and the corrected results of the last completed core op
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rv_vld_q  <= 1'b0;
            rv_sgn_q  <= 1'b0;
            rv_rs1_q  <= '0;
            rv_rs2_q  <= '0;
            rv_quo_q  <= '0;
            rv_rem_q  <= '0;
            req_sgn_q <= 1'b0;
            req_rs1_q <= '0;
            req_rs2_q <= '0;
        end else begin
            if (accept && !special) begin
                req_sgn_q <= op_signed;
                req_rs1_q <= in_rs1;
                req_rs2_q <= in_rs2;
            end
            if (state_q == S_DRAIN && flush) begin
                rv_vld_q <= 1'b0;
            end else if (state_q == S_WAIT && core_done && !flush) begin
                rv_vld_q <= 1'b1;
                rv_sgn_q <= req_sgn_q;
                rv_rs1_q <= req_rs1_q;
                rv_rs2_q <= req_rs2_q;
                rv_quo_q <= quo_fix;
                rv_rem_q <= rem_fix;
            end
        end
    end
`else
    assign reuse_hit = 1'b0;
    assign reuse_res = '0;
`endif

    // Control FSM with all handshake and datapath outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            core_start_q    <= 1'b0;
            core_dividend_q <= '0;
            core_divisor_q  <= '0;
            out_valid_q     <= 1'b0;
            out_result_q    <= '0;
            out_tag_q       <= '0;
            rem_q           <= 1'b0;
            neg_quo_q       <= 1'b0;
            neg_rem_q       <= 1'b0;
        end else begin
            core_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        out_tag_q <= in_tag;
                        rem_q     <= op_rem;
                        if (special) begin
                            out_result_q <= spec_res;
                            out_valid_q  <= 1'b1;
                            state_q      <= S_RESP;
                        end else if (reuse_hit) begin
                            out_result_q <= reuse_res;
                            out_valid_q  <= 1'b1;
                            state_q      <= S_RESP;
                        end else begin
                            core_dividend_q <= a_mag;
                            core_divisor_q  <= b_mag;
                            neg_quo_q       <= a_neg ^ b_neg;
                            neg_rem_q       <= a_neg;
                            core_start_q    <= 1'b1;
                            state_q         <= S_LAUNCH;
                        end
                    end
                end
                S_LAUNCH: begin
                    state_q <= flush ? S_DRAIN : S_WAIT;
                end
                S_WAIT: begin
                    if (flush) begin
                        state_q <= core_done ? S_IDLE : S_DRAIN;
                    end else if (core_done) begin
                        out_result_q <= res_fix;
                        out_valid_q  <= 1'b1;
                        state_q      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (flush || out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (core_done) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready      = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign core_start    = core_start_q;
    assign core_dividend = core_dividend_q;
    assign core_divisor  = core_divisor_q;
    assign out_valid     = out_valid_q;
    assign out_result    = out_result_q;
    assign out_tag       = out_tag_q;

endmodule

// File: tb/tb_rv32m_div_ctrl.sv
// Bench for rv32m_div_ctrl: behavioural divider core, expected-result scoreboard, directed and random ops.
// Inputs driven 1 ns after posedge; outputs sampled at the same point; core model acts on negedges.
// Covers reset, special cases, sign handling, backpressure, flush in each state and optional reuse.
module tb_rv32m_div_ctrl;

    localparam int DW    = 32;
    localparam int TAG_W = 5;
    localparam logic [DW-1:0] INT_MIN = 32'h8000_0000;

`ifdef DIV_RESULT_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       in_funct3 = 3'b0;
    logic [DW-1:0]    in_rs1 = '0;
    logic [DW-1:0]    in_rs2 = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             flush = 1'b0;
    logic             core_start;
    logic [DW-1:0]    core_dividend;
    logic [DW-1:0]    core_divisor;
    logic             core_done = 1'b0;
    logic [DW-1:0]    core_quotient = '0;
    logic [DW-1:0]    core_remainder = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [DW-1:0]    out_result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    always #5 clk = ~clk;

    rv32m_div_ctrl #(.DW(DW), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag), .flush(flush),
        .core_start(core_start), .core_dividend(core_dividend), .core_divisor(core_divisor),
        .core_done(core_done), .core_quotient(core_quotient), .core_remainder(core_remainder),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .busy(busy)
    );

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [DW-1:0]    res;
    } exp_t;

    exp_t          sb_q[$];
    logic [2*DW-1:0] core_exp_q[$];

    int n_assert = 0;
    int n_fail   = 0;
    int core_lat = 3;
    int start_cnt = 0;
    int done_cnt  = 0;

    // bench-side record of what the reuse store should hold
    logic          rv_vld = 1'b0;
    logic          rv_sgn = 1'b0;
    logic [DW-1:0] rv_a = '0;
    logic [DW-1:0] rv_b = '0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Behavioural unsigned divider core
    logic          pending = 1'b0;
    int            cnt = 0;
    logic [DW-1:0] cap_a = '0;
    logic [DW-1:0] cap_b = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            pending   = 1'b0;
            core_done = 1'b0;
        end else begin
            core_done = 1'b0;
            if (pending) begin
                chk("core_dividend_stable", core_dividend, cap_a);
                chk("core_divisor_stable", core_divisor, cap_b);
                cnt--;
                if (cnt == 0) begin
                    core_quotient  = (cap_b == '0) ? '1 : cap_a / cap_b;
                    core_remainder = (cap_b == '0) ? cap_a : cap_a % cap_b;
                    core_done      = 1'b1;
                    pending        = 1'b0;
                    done_cnt++;
                end
            end
            if (core_start) begin
                logic [2*DW-1:0] e;
                start_cnt++;
                chk("core_start_while_busy", DW'(pending), '0);
                chk("core_start_expected", DW'(core_exp_q.size() != 0), 1);
                if (core_exp_q.size() != 0) begin
                    e = core_exp_q.pop_front();
                    chk("core_dividend", core_dividend, e[2*DW-1:DW]);
                    chk("core_divisor", core_divisor, e[DW-1:0]);
                end
                cap_a   = core_dividend;
                cap_b   = core_divisor;
                pending = 1'b1;
                cnt     = core_lat;
            end
        end
    end

    function automatic logic [DW-1:0] ref_res(input logic [2:0] f3, input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic sgn;
        logic rem;
        sgn = f3[2] & ~f3[0];
        rem = f3[2] & f3[1];
        if (b == '0) return rem ? a : '1;
        if (sgn) begin
            if (a == INT_MIN && b == '1) return rem ? '0 : INT_MIN;
            return rem ? DW'($signed(a) % $signed(b)) : DW'($signed(a) / $signed(b));
        end
        return rem ? a % b : a / b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] f3, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [TAG_W-1:0] t);
        in_funct3 = f3;
        in_rs1    = a;
        in_rs2    = b;
        in_tag    = t;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
    endtask

    // Full op with out_ready high: checks launch, latency, result, tag and handshake
    task automatic run_op(input string name, input logic [2:0] f3, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [TAG_W-1:0] t, input logic [DW-1:0] exp_res);
        logic sgn;
        logic spec;
        logic hit;
        logic use_core;
        int   s0;
        int   k;
        exp_t e;
        sgn      = f3[2] & ~f3[0];
        spec     = (b == '0) || (sgn && a == INT_MIN && b == '1);
        hit      = REUSE && rv_vld && rv_a == a && rv_b == b && rv_sgn == sgn;
        use_core = !spec && !hit;
        s0       = start_cnt;
        chk({name, "_in_ready"}, DW'(in_ready), 1);
        sb_q.push_back({t, exp_res});
        if (use_core)
            core_exp_q.push_back({(sgn && a[DW-1]) ? -a : a, (sgn && b[DW-1]) ? -b : b});
        send(f3, a, b, t);
        chk({name, "_start"}, DW'(core_start), DW'(use_core));
        k = 0;
        while (!out_valid && k < 200) begin
            tick();
            k++;
        end
        chk({name, "_valid"}, DW'(out_valid), 1);
        chk({name, "_latency"}, DW'(k), use_core ? DW'(core_lat + 1) : '0);
        chk({name, "_sb_nonempty"}, DW'(sb_q.size() != 0), 1);
        if (out_valid && sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk({name, "_result"}, out_result, e.res);
            chk({name, "_tag"}, DW'(out_tag), DW'(e.tag));
        end
        tick();
        chk({name, "_valid_drop"}, DW'(out_valid), 0);
        chk({name, "_core_starts"}, DW'(start_cnt - s0), DW'(use_core));
        if (use_core) begin
            rv_vld = 1'b1;
            rv_a   = a;
            rv_b   = b;
            rv_sgn = sgn;
        end
    endtask

    initial begin
        logic [2:0]    f3;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] held_res;
        int            sel;
        int            k;
        int            d0;
        exp_t          e;

        // Reset values
        tick();
        tick();
        chk("rst_core_start", DW'(core_start), 0);
        chk("rst_out_valid", DW'(out_valid), 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_tag", DW'(out_tag), 0);
        chk("rst_core_dividend", core_dividend, 0);
        chk("rst_core_divisor", core_divisor, 0);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", DW'(in_ready), 1);
        chk("rst_busy", DW'(busy), 0);

        // Directed ops
        run_op("divu_11_3", 3'b101, 32'd11, 32'd3, 5'd1, 32'd3);
        run_op("remu_11_3", 3'b111, 32'd11, 32'd3, 5'd2, 32'd2);
        run_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFD);
        run_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFF);
        run_op("div_by_zero", 3'b100, 32'd10, 32'd0, 5'd5, 32'hFFFF_FFFF);
        run_op("rem_by_zero", 3'b110, 32'd10, 32'd0, 5'd6, 32'd10);
        run_op("div_ovf", 3'b100, INT_MIN, 32'hFFFF_FFFF, 5'd7, INT_MIN);
        run_op("rem_ovf", 3'b110, INT_MIN, 32'hFFFF_FFFF, 5'd8, 32'd0);
        run_op("f3_000_as_divu", 3'b000, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'h7FFF_FFFC);
        run_op("div_intmin_3", 3'b100, INT_MIN, 32'd3, 5'd10, 32'hD555_5556);
        run_op("rem_7_m3", 3'b110, 32'd7, 32'hFFFF_FFFD, 5'd11, 32'd1);
        run_op("div_100_7", 3'b100, 32'd100, 32'd7, 5'd12, 32'd14);
        run_op("rem_100_7", 3'b110, 32'd100, 32'd7, 5'd13, 32'd2);

        // Backpressure: result and tag held for 5 cycles, no new accept
        out_ready = 1'b0;
        core_exp_q.push_back({32'd20, 32'd4});
        sb_q.push_back({5'd14, 32'd5});
        send(3'b101, 32'd20, 32'd4, 5'd14);
        rv_vld = 1'b1; rv_a = 32'd20; rv_b = 32'd4; rv_sgn = 1'b0;
        k = 0;
        while (!out_valid && k < 200) begin
            tick();
            k++;
        end
        chk("bp_valid", DW'(out_valid), 1);
        e = sb_q.pop_front();
        held_res = out_result;
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_valid", DW'(out_valid), 1);
            chk("bp_hold_result", out_result, e.res);
            chk("bp_hold_tag", DW'(out_tag), DW'(e.tag));
            chk("bp_in_ready_low", DW'(in_ready), 0);
            tick();
        end
        chk("bp_stable_result", out_result, held_res);
        out_ready = 1'b1;
        tick();
        chk("bp_release_in_ready", DW'(in_ready), 1);
        chk("bp_release_valid", DW'(out_valid), 0);

        // Flush in RESP drops the result
        out_ready = 1'b0;
        send(3'b100, 32'd10, 32'd0, 5'd15);
        chk("flush_resp_valid_before", DW'(out_valid), 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        out_ready = 1'b1;
        chk("flush_resp_valid_after", DW'(out_valid), 0);
        chk("flush_resp_in_ready", DW'(in_ready), 1);

        // Flush in IDLE blocks a simultaneous offer
        d0 = start_cnt;
        flush = 1'b1;
        send(3'b101, 32'd7, 32'd1, 5'd16);
        flush = 1'b0;
        chk("flush_idle_in_ready", DW'(in_ready), 1);
        chk("flush_idle_no_start", DW'(core_start), 0);
        tick();
        chk("flush_idle_no_valid", DW'(out_valid), 0);
        chk("flush_idle_starts", DW'(start_cnt - d0), 0);

        // Flush in WAIT, held into DRAIN: wait for the core, no output
        core_lat = 12;
        d0 = done_cnt;
        core_exp_q.push_back({32'd50, 32'd5});
        send(3'b101, 32'd50, 32'd5, 5'd17);
        tick();
        flush = 1'b1;
        tick();
        tick();
        flush = 1'b0;
        rv_vld = 1'b0;
        k = 0;
        while (!in_ready && k < 40) begin
            chk("flush_wait_no_valid", DW'(out_valid), 0);
            tick();
            k++;
        end
        chk("flush_wait_in_ready", DW'(in_ready), 1);
        chk("flush_wait_release_cycle", DW'(k), DW'(core_lat - 2));
        chk("flush_wait_core_done_seen", DW'(done_cnt - d0), 1);
        tick();
        chk("flush_wait_still_no_valid", DW'(out_valid), 0);
        core_lat = 3;
        run_op("after_flush_divu_50_5", 3'b101, 32'd50, 32'd5, 5'd18, 32'd10);
        run_op("after_flush_rem_100_7", 3'b110, 32'd100, 32'd7, 5'd19, 32'd2);
        run_op("reuse_div_100_7", 3'b100, 32'd100, 32'd7, 5'd20, 32'd14);

        // Random ops against the reference model
        for (int i = 0; i < 24; i++) begin
            f3  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) b = '0;
            if (sel == 1) begin a = INT_MIN; b = '1; end
            if (sel == 2) b = DW'($urandom_range(1, 20));
            core_lat = $urandom_range(1, 4);
            run_op("rand", f3, a, b, TAG_W'(i), ref_res(f3, a, b));
        end

        // Reset in the middle of a core op abandons it
        core_lat = 8;
        core_exp_q.push_back({32'd90, 32'd9});
        send(3'b101, 32'd90, 32'd9, 5'd21);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", DW'(out_valid), 0);
        chk("mid_rst_core_dividend", core_dividend, 0);
        chk("mid_rst_out_result", out_result, 0);
        tick();
        rst_n = 1'b1;
        rv_vld = 1'b0;
        tick();
        chk("mid_rst_in_ready", DW'(in_ready), 1);
        for (int i = 0; i < 10; i++) begin
            chk("mid_rst_no_valid", DW'(out_valid), 0);
            tick();
        end
        core_lat = 2;
        run_op("post_rst_divu_90_9", 3'b101, 32'd90, 32'd9, 5'd22, 32'd10);

        chk("sb_empty", DW'(sb_q.size()), 0);
        chk("core_exp_empty", DW'(core_exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
